// File: rtl/noc_pkg.sv
// Shared mesh NoC constants: flit layout, switch port indices and XY routing.
package noc_pkg;

  localparam int unsigned FLIT_W    = 20;
  localparam int unsigned DX_HI     = 19;
  localparam int unsigned DX_LO     = 18;
  localparam int unsigned DY_HI     = 17;
  localparam int unsigned DY_LO     = 16;
  localparam int unsigned COORD_W   = 2;
  localparam int unsigned MESH_DIM  = 4;
  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned PORT_N    = 0;
  localparam int unsigned PORT_S    = 1;
  localparam int unsigned PORT_E    = 2;
  localparam int unsigned PORT_W    = 3;
  localparam int unsigned PORT_L    = 4;
  localparam int unsigned CREDITS   = 4;
  localparam int unsigned CNT_W     = $clog2(CREDITS + 1);

  typedef logic [NUM_PORTS-1:0] req_t;
  typedef logic [COORD_W-1:0]   coord_t;

  // X first, then Y; exactly one bit set in the result.
  function automatic req_t xy_route(input coord_t dx, input coord_t dy,
                                    input coord_t mx, input coord_t my);
    req_t r;
    r = '0;
    if (dx > mx)      r[PORT_E] = 1'b1;
    else if (dx < mx) r[PORT_W] = 1'b1;
    else if (dy > my) r[PORT_S] = 1'b1;
    else if (dy < my) r[PORT_N] = 1'b1;
    else              r[PORT_L] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/router_input_port_if.sv
// PE flit stream in, switch request/grant out, credit return and status.
interface router_input_port_if;
  import noc_pkg::*;

  logic [FLIT_W-1:0] datain;
  logic              in_valid;
  logic              co;
  logic [FLIT_W-1:0] flit_out;
  req_t              req;
  logic              grant;
  logic [CNT_W-1:0]  count;
  logic              ovf_err;

  modport master (output datain, in_valid, grant,
                  input  co, flit_out, req, count, ovf_err);
  modport slave  (input  datain, in_valid, grant,
                  output co, flit_out, req, count, ovf_err);
endinterface

// File: rtl/flit_fifo.sv
// Circular flit buffer with occupancy count; push into a full FIFO is allowed
// only when a pop happens on the same edge.
module flit_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/router_input_port.sv
// Local input port of mesh node (MY_X, MY_Y): buffers PE flits, raises an XY
// switch request for the head flit and returns one credit per flit forwarded.
module router_input_port
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH = FLIT_W,
  parameter int unsigned DEPTH = CREDITS,
  parameter int unsigned MY_X  = 1,
  parameter int unsigned MY_Y  = 3
) (
  input logic                clk,
  input logic                RST,
  router_input_port_if.slave port_if
);
  logic             push, pop, full, empty;
  logic [WIDTH-1:0] head;
  logic [CNT_W-1:0] fifo_count;
  logic             co_q, co_d;
  logic             ovf_err_q, ovf_err_d;

  assign pop  = port_if.grant && !empty;
  assign push = port_if.in_valid && (!full || pop);

  flit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (RST),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (port_if.datain),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Head is masked while empty so stale storage never reaches the crossbar.
  assign port_if.flit_out = empty ? '0 : head;
  assign port_if.req      = empty ? '0 :
                            xy_route(head[DX_HI:DX_LO], head[DY_HI:DY_LO],
                                     COORD_W'(MY_X), COORD_W'(MY_Y));
  assign port_if.count    = fifo_count;
  assign port_if.co       = co_q;
  assign port_if.ovf_err  = ovf_err_q;

  always_comb begin
    co_d      = pop;
    ovf_err_d = ovf_err_q || (port_if.in_valid && !push);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      co_q      <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      co_q      <= co_d;
      ovf_err_q <= ovf_err_d;
    end
  end

endmodule
